// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types
// for the CPU register file slice.
package cpu_pkg;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 4;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  typedef enum logic {
    SCRUB = 1'b0,
    READY = 1'b1
  } scrub_state_t;

endpackage

// File: rtl/register_file_ram_if.sv
// register_file_ram_if: read/write port bundle
// between the pipeline and the register file.
interface register_file_ram_if #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
);

  logic [ADDR_W-1:0] RS;
  logic [ADDR_W-1:0] RT;
  logic [ADDR_W-1:0] RD;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic [DATA_W-1:0] ReadRS;
  logic [DATA_W-1:0] ReadRT;
  logic              Busy;

  modport master (
    output RS,
    output RT,
    output RD,
    output WriteData,
    output RegWrite,
    input  ReadRS,
    input  ReadRT,
    input  Busy
  );

  modport slave (
    input  RS,
    input  RT,
    input  RD,
    input  WriteData,
    input  RegWrite,
    output ReadRS,
    output ReadRT,
    output Busy
  );

endinterface

// File: rtl/regfile_scrub_ctrl.sv
// regfile_scrub_ctrl: post-reset clear sequencer,
// one entry per cycle, Busy until the last entry.
module regfile_scrub_ctrl #(
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int NUM_REGS = 2**ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              Busy,
  output logic              ClrWe,
  output logic [ADDR_W-1:0] ClrIdx
);

  import cpu_pkg::*;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_REGS - 1);

  // Power-up value makes the first NUM_REGS
  // cycles scrub even without a Reset pulse.
  scrub_state_t      state = SCRUB;
  scrub_state_t      state_n;
  logic [ADDR_W-1:0] idx = '0;
  logic [ADDR_W-1:0] idx_n;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= SCRUB;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      SCRUB: begin
        if (idx == LAST) begin
          state_n = READY;
          idx_n   = '0;
        end else begin
          idx_n = idx + ADDR_W'(1);
        end
      end
      READY: begin
        state_n = READY;
      end
      default: begin
        state_n = SCRUB;
        idx_n   = '0;
      end
    endcase
  end

  always_comb begin
    Busy   = (state == SCRUB);
    ClrWe  = (state == SCRUB) && !Reset;
    ClrIdx = idx;
  end

endmodule

// File: rtl/register_file_ram.sv
// register_file_ram: 2R/1W register file on
// distributed RAM with scrub, zero reg and bypass.
module register_file_ram #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int NUM_REGS = 2**ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic                Clock,
  input logic                Reset,
  register_file_ram_if.slave bus
);

  import cpu_pkg::*;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;

  logic              wr_ok;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  logic rs_ok;
  logic rt_ok;

  regfile_scrub_ctrl #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scrub (
    .Clock  (Clock),
    .Reset  (Reset),
    .Busy   (busy),
    .ClrWe  (clr_we),
    .ClrIdx (clr_idx)
  );

  assign bus.Busy = busy;

  // A usable index is in range and not the
  // hardwired zero register.
  always_comb begin
    wr_ok = bus.RegWrite && !busy &&
            (int'(bus.RD) < NUM_REGS) &&
            !(ZERO_REG && bus.RD == '0);
    rs_ok = (int'(bus.RS) < NUM_REGS) &&
            !(ZERO_REG && bus.RS == '0);
    rt_ok = (int'(bus.RT) < NUM_REGS) &&
            !(ZERO_REG && bus.RT == '0);
  end

  always_comb begin
    wen   = clr_we || wr_ok;
    waddr = clr_we ? clr_idx : bus.RD;
    wdata = clr_we ? '0 : bus.WriteData;
  end

  // No reset on the array so it maps to LUT RAM.
  always_ff @(posedge Clock) begin
    if (wen) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    bus.ReadRS = '0;
    if (!busy && rs_ok) begin
      if (BYPASS && wr_ok && bus.RD == bus.RS) begin
        bus.ReadRS = bus.WriteData;
      end else begin
        bus.ReadRS = regs[bus.RS];
      end
    end
  end

  always_comb begin
    bus.ReadRT = '0;
    if (!busy && rt_ok) begin
      if (BYPASS && wr_ok && bus.RD == bus.RT) begin
        bus.ReadRT = bus.WriteData;
      end else begin
        bus.ReadRT = regs[bus.RT];
      end
    end
  end

endmodule

// File: doc/register_file_ram.md
Name: register_file_ram

Overview:
- Next-generation CPU register file: parametrised data width and depth, two asynchronous read ports (RS, RT), one synchronous write port (RD) qualified by RegWrite.
- Storage is written so it maps to distributed RAM, which has no flat reset. After Reset, a scrub state machine clears every entry, one per cycle.
- Adds an optional hardwired zero register and optional write-to-read bypass, so the decode/execute stage sees a same-cycle write.

Parameters:
- DATA_W, 24, register width in bits
- ADDR_W, 4, register index width
- NUM_REGS, 2**ADDR_W, number of registers; must be ≤ 2**ADDR_W and ≥ 2
- ZERO_REG, 1, 1 = index 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = a write to the read index is forwarded combinationally to that read port in the same cycle

Ports:
- Clock  in  1  sole clock, rising edge
- Reset  in  1  synchronous, active-high; starts the scrub
- RS  in  ADDR_W  read index, port A
- RT  in  ADDR_W  read index, port B
- RD  in  ADDR_W  write index
- WriteData  in  DATA_W  write data
- RegWrite  in  1  write enable
- ReadRS  out  DATA_W  port A data, combinational
- ReadRT  out  DATA_W  port B data, combinational
- Busy  out  1  high while scrubbing; writes are dropped and reads are forced to 0

Behaviour:
- One clock, `Clock`. Reset is synchronous and active-high, port `Reset`.
- States:
  - SCRUB: entered on any rising edge with Reset=1. ClrIdx is loaded with 0 and Busy is registered to 1.
  - READY.
- SCRUB operation:
  - Each edge with Reset=0 writes 0 to entry ClrIdx, then ClrIdx increments.
  - On the edge that writes entry NUM_REGS-1, go to READY, Busy→0.
  - Scrub lasts exactly NUM_REGS cycles after Reset deasserts.
- Reset held high: stays in SCRUB, ClrIdx held at 0, no entries written.
- Reset reasserted mid-scrub: ClrIdx restarts at 0.
- Reset during READY: contents are not guaranteed until Busy falls.
- Reset values: Busy=1 and ClrIdx=0 after the reset edge. ReadRS and ReadRT read 0 while Busy=1.
- Power-up (no Reset yet): the state register initialises to SCRUB with ClrIdx=0, so the first NUM_REGS cycles scrub.
- READY write:
  - On the rising edge with RegWrite=1, Registers[RD] ← WriteData.
  - RegWrite=0: no write. This fixes the previous generation, which wrote every cycle.
- Index out of range (RD or RS/RT ≥ NUM_REGS, possible only when NUM_REGS < 2**ADDR_W):
  - Write is dropped.
  - Read returns 0.
- ZERO_REG=1:
  - Write to index 0 is dropped; the scrub still clears it.
  - Read of index 0 returns 0 regardless of storage or bypass.
- Read latency: 0 cycles (asynchronous).
  - BYPASS=0: a write becomes visible the cycle after its edge.
  - BYPASS=1: when Busy=0, RegWrite=1, RD==RS and RD is a legal, non-zero-reg index, ReadRS=WriteData in the same cycle. ReadRT follows the same rule.
- Simultaneous cases:
  - RS==RT: both ports return identical data.
  - Write and read of different indices: no interaction.
  - RegWrite during Busy: dropped silently; no queuing.
- Width: all data is DATA_W. Entries of width DATA_W are cleared with a sized zero; no truncation.

Decomposition:
- Shared package `cpu_pkg`:
  - DATA_W=24 and ADDR_W=4 constants
  - a register-index typedef
  - the scrub state enum (SCRUB, READY)
- One natural sub-module, `regfile_scrub_ctrl`. It contains the state, ClrIdx counter and Busy logic, and outputs the clear-write enable and index. The top contains the storage array, write mux (scrub vs. normal), and read/bypass/zero muxing.

Test Plan:
- Power-up scrub, then Reset pulse of 1 cycle with default params → Busy=1 for exactly 16 cycles after Reset falls; all 16 registers read 0 afterwards.
- Write R5←0xABCDEF with RegWrite=1, RS=5, BYPASS=1 → ReadRS=0xABCDEF in the same cycle.
  - Same with BYPASS=0 → old value (0) that cycle, 0xABCDEF next cycle.
- RegWrite=0 with RD=3, WriteData=0x123456 → R3 stays 0.
  - Then write R0←0xFFFFFF with ZERO_REG=1 → ReadRS(RS=0)=0; the bypass does not forward to index 0.
- Fill R1..R15 with index*0x010101, then assert Reset at scrub cycle 7 and again at cycle 3 → Busy stays high 16 cycles after the final deassert; all registers end at 0.
- During Busy, drive RegWrite=1, RD=9, WriteData=0x555555 and RS=RT=9 → ReadRS=ReadRT=0; after Busy falls, R9=0.
- NUM_REGS=12, ADDR_W=4: write RD=13 and read RS=13 → write dropped, read 0; Busy lasts 12 cycles.
